// File: rtl/matmul_ctrl_if.sv
// rtl/matmul_ctrl_if.sv - requester, datapath and completion signals of the matmul controller
interface matmul_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int N_REQ      = 2
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int NF      = MAX_DIM * MAX_DIM;
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid_i;
    logic [6*N_REQ-1:0] req_dim_i;
    logic [N_REQ-1:0]   req_ready_o;
    logic               calc_start_o;
    logic [1:0]         calc_dim_n_o;
    logic [1:0]         calc_dim_k_o;
    logic [1:0]         calc_dim_m_o;
    logic               calc_done_i;
    logic [NF-1:0]      calc_flags_i;
    logic               done_o;
    logic [IDW-1:0]     done_id_o;
    logic [NF-1:0]      done_flags_o;
    logic               overflow_o;
    logic               err_o;
    logic               busy_o;

    // Controller side
    modport slave (
        input  req_valid_i, req_dim_i, calc_done_i, calc_flags_i,
        output req_ready_o, calc_start_o, calc_dim_n_o, calc_dim_k_o, calc_dim_m_o,
        output done_o, done_id_o, done_flags_o, overflow_o, err_o, busy_o
    );

    // Requesters and datapath side
    modport master (
        output req_valid_i, req_dim_i, calc_done_i, calc_flags_i,
        input  req_ready_o, calc_start_o, calc_dim_n_o, calc_dim_k_o, calc_dim_m_o,
        input  done_o, done_id_o, done_flags_o, overflow_o, err_o, busy_o
    );
endinterface

// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - round-robin job controller for a small matrix-multiply datapath
module matmul_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int N_REQ      = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    matmul_ctrl_if.slave  bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int NF      = MAX_DIM * MAX_DIM;
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] job_id_q;
    logic [5:0]     dims_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;
    logic           err_q;
    logic [IDW-1:0] done_id_q;
    logic [NF-1:0]  flags_q;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [5:0]     grant_dims;
    logic           dims_zero;
    logic           accept;
    logic           run_timeout;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        int unsigned sel;
        grant_found = 1'b0;
        grant_idx   = '0;
        sel         = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            sel = (int'(ptr_q) + off) % N_REQ;
            if (!grant_found && bus.req_valid_i[sel]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(sel);
            end
        end
    end

    assign grant_dims  = bus.req_dim_i[6*int'(grant_idx) +: 6];
    assign dims_zero   = (grant_dims[5:4] == 2'd0) || (grant_dims[3:2] == 2'd0) ||
                         (grant_dims[1:0] == 2'd0);
    // No acceptance while reset is held, so a requester never sees a lost grant
    assign accept      = (state_q == S_IDLE) && grant_found && !rst_i;
    assign run_timeout = (cnt_q == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rejected jobs never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !dims_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.calc_done_i || run_timeout) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job bookkeeping: pointer, dims, cycle counter and completion pulse/status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= IDW'(N_REQ - 1);
            job_id_q  <= '0;
            dims_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            done_id_q <= '0;
            flags_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        ptr_q    <= grant_idx;
                        job_id_q <= grant_idx;
                        if (dims_zero) begin
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            done_id_q <= grant_idx;
                            flags_q   <= '0;
                        end else begin
                            dims_q <= grant_dims;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A completion in the timeout cycle still counts as normal
                    if (bus.calc_done_i) begin
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        done_id_q <= job_id_q;
                        flags_q   <= bus.calc_flags_i;
                    end else if (run_timeout) begin
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        done_id_q <= job_id_q;
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Outputs decoded from state and registered job status
    always_comb begin
        bus.req_ready_o = '0;
        if (accept) begin
            bus.req_ready_o[grant_idx] = 1'b1;
        end
        bus.calc_start_o = (state_q == S_RUN);
        bus.busy_o       = (state_q != S_IDLE);
        bus.calc_dim_n_o = dims_q[5:4];
        bus.calc_dim_k_o = dims_q[3:2];
        bus.calc_dim_m_o = dims_q[1:0];
        bus.done_o       = done_q;
        bus.err_o        = err_q;
        bus.done_id_o    = done_id_q;
        bus.done_flags_o = flags_q;
        bus.overflow_o   = |flags_q;
    end
endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - directed vector bench for matmul_ctrl
module tb_matmul_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    matmul_ctrl_if #(.DATA_WIDTH(8), .BUS_WIDTH(32), .N_REQ(2)) bus ();

    matmul_ctrl #(.DATA_WIDTH(8), .BUS_WIDTH(32), .N_REQ(2), .TIMEOUT(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          rep;
        logic        rst;
        logic [1:0]  valid;
        logic [11:0] dims;
        logic        cdone;
        logic [15:0] flags;
        logic [1:0]  e_ready;
        logic        e_start;
        logic        e_done;
        logic        e_err;
        logic        e_id;
        logic        e_busy;
        logic [15:0] e_flags;
        logic [5:0]  e_dims;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input int rep, input logic r, input logic [1:0] v,
                                 input logic [11:0] d, input logic cd, input logic [15:0] f,
                                 input logic [1:0] erdy, input logic est, input logic edn,
                                 input logic eer, input logic eid, input logic ebsy,
                                 input logic [15:0] efl, input logic [5:0] edim);
        vec_t x;
        x.rep = rep; x.rst = r; x.valid = v; x.dims = d; x.cdone = cd; x.flags = f;
        x.e_ready = erdy; x.e_start = est; x.e_done = edn; x.e_err = eer; x.e_id = eid;
        x.e_busy = ebsy; x.e_flags = efl; x.e_dims = edim;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [11:0] d,
                         input logic cd, input logic [15:0] f);
        rst              = r;
        bus.req_valid_i  = v;
        bus.req_dim_i    = d;
        bus.calc_done_i  = cd;
        bus.calc_flags_i = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] exp, input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.req_ready_o != 2'b00) begin
                seen = 1'b1;
                chk(name, 32'(bus.req_ready_o), 32'(exp));
            end
            tick();
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no grant expected ready=%0h", name, exp);
        end
    endtask

    initial begin
        logic        seen;
        int          nstart;
        int          ng;
        logic [1:0]  g_idx [4];
        int          g_cyc [4];

        drive(1'b1, 2'b00, 12'h000, 1'b0, 16'h0000);
        tick();
        tick();

        // Reset state, 12-cycle job, ignored late done, reject of zero dims
        tbl.push_back(mkv(1,  1, 2'b01, 12'h03F, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 0, 16'h0000, 6'h00));
        tbl.push_back(mkv(1,  0, 2'b01, 12'h03F, 0, 16'h0000, 2'b01, 0, 0, 0, 0, 0, 16'h0000, 6'h00));
        tbl.push_back(mkv(11, 0, 2'b00, 12'h000, 0, 16'h0000, 2'b00, 1, 0, 0, 0, 1, 16'h0000, 6'h3F));
        tbl.push_back(mkv(1,  0, 2'b00, 12'h000, 1, 16'h0010, 2'b00, 1, 0, 0, 0, 1, 16'h0000, 6'h3F));
        tbl.push_back(mkv(1,  0, 2'b00, 12'h000, 1, 16'h0020, 2'b00, 0, 1, 0, 0, 1, 16'h0010, 6'h3F));
        tbl.push_back(mkv(1,  0, 2'b10, 12'h280, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 1, 16'h0010, 6'h3F));
        tbl.push_back(mkv(1,  0, 2'b10, 12'h280, 0, 16'h0000, 2'b10, 0, 0, 0, 0, 0, 16'h0010, 6'h3F));
        tbl.push_back(mkv(1,  0, 2'b00, 12'h000, 0, 16'h0000, 2'b00, 0, 1, 1, 1, 0, 16'h0000, 6'h3F));
        tbl.push_back(mkv(2,  0, 2'b00, 12'h000, 0, 16'h0000, 2'b00, 0, 0, 0, 1, 0, 16'h0000, 6'h3F));

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                drive(tbl[i].rst, tbl[i].valid, tbl[i].dims, tbl[i].cdone, tbl[i].flags);
                @(negedge clk);
                chk($sformatf("v%0d.%0d ready", i, r), 32'(bus.req_ready_o), 32'(tbl[i].e_ready));
                chk($sformatf("v%0d.%0d start", i, r), 32'(bus.calc_start_o), 32'(tbl[i].e_start));
                chk($sformatf("v%0d.%0d done", i, r), 32'(bus.done_o), 32'(tbl[i].e_done));
                chk($sformatf("v%0d.%0d err", i, r), 32'(bus.err_o), 32'(tbl[i].e_err));
                chk($sformatf("v%0d.%0d id", i, r), 32'(bus.done_id_o), 32'(tbl[i].e_id));
                chk($sformatf("v%0d.%0d busy", i, r), 32'(bus.busy_o), 32'(tbl[i].e_busy));
                chk($sformatf("v%0d.%0d flags", i, r), 32'(bus.done_flags_o), 32'(tbl[i].e_flags));
                chk($sformatf("v%0d.%0d ovf", i, r), 32'(bus.overflow_o), 32'(|tbl[i].e_flags));
                chk($sformatf("v%0d.%0d dims", i, r),
                    32'({bus.calc_dim_n_o, bus.calc_dim_k_o, bus.calc_dim_m_o}), 32'(tbl[i].e_dims));
                tick();
            end
        end

        // Both requesters valid: grants alternate, spaced by RUN + 2 DRAIN + IDLE
        drive(1'b0, 2'b11, 12'h6FF, 1'b1, 16'h0101);
        ng = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.req_ready_o != 2'b00 && ng < 4) begin
                chk("rr_onehot", 32'($onehot(bus.req_ready_o)), 32'd1);
                g_idx[ng] = bus.req_ready_o;
                g_cyc[ng] = c;
                ng++;
            end
            tick();
            if (ng == 4) bus.req_valid_i = 2'b00;
        end
        chk("rr_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(g_idx[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
        end
        @(negedge clk);
        chk("rr_last_id", 32'(bus.done_id_o), 32'd1);
        chk("rr_flags", 32'(bus.done_flags_o), 32'h0101);
        chk("rr_idle", 32'(bus.busy_o), 32'd0);
        tick();

        // Datapath never completes: timeout with flags left untouched
        drive(1'b0, 2'b01, 12'h03F, 1'b0, 16'hFFFF);
        wait_grant(2'b01, "to_grant");
        bus.req_valid_i = 2'b00;
        nstart = 0;
        seen   = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.calc_start_o) nstart++;
            if (bus.done_o) begin
                seen = 1'b1;
                chk("to_err", 32'(bus.err_o), 32'd1);
                chk("to_id", 32'(bus.done_id_o), 32'd0);
                chk("to_flags_held", 32'(bus.done_flags_o), 32'h0101);
                chk("to_ovf", 32'(bus.overflow_o), 32'd1);
                chk("to_start_low", 32'(bus.calc_start_o), 32'd0);
            end
            tick();
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL to_done: got no done_o expected done after 64 run cycles");
        end
        chk("to_start_cycles", 32'(nstart), 32'd64);
        @(negedge clk);
        chk("to_drain2_busy", 32'(bus.busy_o), 32'd1);
        chk("to_drain2_done", 32'(bus.done_o), 32'd0);
        tick();
        @(negedge clk);
        chk("to_idle_busy", 32'(bus.busy_o), 32'd0);
        tick();

        // Reset mid-RUN: no completion, start drops, requester 0 wins next
        drive(1'b0, 2'b01, 12'h03F, 1'b0, 16'h0000);
        wait_grant(2'b01, "rst_grant");
        bus.req_valid_i = 2'b00;
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_done", 32'(bus.done_o), 32'd0);
        tick();
        drive(1'b0, 2'b11, 12'h6FF, 1'b1, 16'h0000);
        @(negedge clk);
        chk("rst_start_low", 32'(bus.calc_start_o), 32'd0);
        chk("rst_done_low", 32'(bus.done_o), 32'd0);
        chk("rst_busy_low", 32'(bus.busy_o), 32'd0);
        chk("rst_flags_clr", 32'(bus.done_flags_o), 32'd0);
        chk("rst_next_grant", 32'(bus.req_ready_o), 32'd1);
        tick();
        bus.req_valid_i = 2'b00;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.done_o) begin
                seen = 1'b1;
                chk("post_rst_id", 32'(bus.done_id_o), 32'd0);
                chk("post_rst_err", 32'(bus.err_o), 32'd0);
            end
            tick();
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL post_rst_done: got no done_o expected one completion");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width in bits.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, bus width in bits; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam).
REQ-003 SHALL have parameter N_REQ, default 2, number of requesters; IDW = max(1, clog2(N_REQ)) (localparam).
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum RUN cycles before abort.
REQ-005 clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 req_valid_i  input  N_REQ  per-requester job request, level.
REQ-008 req_dim_i  input  6*N_REQ  per-requester {N,K,M}, 2 bits each, value = size-1; requester i at bits [6i+5:6i].
REQ-009 req_ready_o  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-010 calc_start_o  output  1  start bit to the datapath.
REQ-011 calc_dim_n_o, calc_dim_k_o, calc_dim_m_o  output  2 each  dimensions to the datapath.
REQ-012 calc_done_i  input  1  datapath result-valid strobe (sp_write).
REQ-013 calc_flags_i  input  MAX_DIM*MAX_DIM  datapath overflow flags.
REQ-014 done_o  output  1  one-cycle job-complete pulse.
REQ-015 done_id_o  output  IDW  requester index of the completed job.
REQ-016 done_flags_o  output  MAX_DIM*MAX_DIM  captured flags; overflow_o  output  1  OR of captured flags.
REQ-017 err_o  output  1  qualifies done_o: job rejected or timed out; busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-019 In IDLE with any req_valid_i bit set, SHALL grant exactly one requester, round-robin, starting at the index after the last grant (index 0 after reset).
REQ-020 Grant cycle: req_ready_o[g]=1, that requester's dims registered, and the FSM SHALL move to RUN on the next edge; the requester SHALL drop req_valid_i or present the next job after seeing ready.
REQ-021 A job with any dim field == 0 SHALL be rejected: req_ready_o pulses, FSM stays IDLE, and on the next cycle done_o=1, err_o=1, done_id_o=g, done_flags_o=0.
REQ-022 In RUN: calc_start_o=1, calc_dim_*_o = registered dims, held stable for the whole state; cycle counter increments from 0.
REQ-023 calc_done_i=1 in RUN: capture calc_flags_i into done_flags_o, done_o=1 and done_id_o=g on the next cycle, err_o=0, then go to DRAIN.
REQ-024 Counter reaching TIMEOUT-1 in RUN without calc_done_i: done_o=1, err_o=1, done_flags_o unchanged, go to DRAIN; calc_done_i and timeout in the same cycle is a normal completion.
REQ-025 DRAIN: calc_start_o=0 for exactly 2 cycles to clear the datapath, then IDLE; no grant is issued in DRAIN.
REQ-026 calc_done_i outside RUN SHALL be ignored.
REQ-027 Minimum spacing between consecutive jobs: start low for 2 cycles plus 1 IDLE grant cycle.
REQ-028 done_o, req_ready_o and err_o SHALL be zero except in the pulse cycles defined above; done_flags_o, overflow_o and done_id_o SHALL hold until the next done_o.

Reset
REQ-029 rst_i=1 SHALL, on the next edge, force IDLE, calc_start_o=0, dims=0, req_ready_o=0, done_o=0, err_o=0, done_id_o=0, done_flags_o=0, overflow_o=0, busy_o=0, counter=0, and round-robin pointer so that requester 0 wins first.
REQ-030 Reset during RUN SHALL abort the job with no done_o pulse; calc_start_o low from the following cycle.

Verification
REQ-031 Req0 {N,K,M}={3,3,3}, datapath model asserts done 12 cycles after start -> ready0 pulse, start high 12 cycles, done_o=1, id=0, err=0, then start low 2 cycles.
REQ-032 Both requesters valid continuously -> grants alternate 0,1,0,1; no back-to-back grants of the same index while the other is valid.
REQ-033 Req1 dims {0,2,2} -> ready1 pulse, start stays 0, next cycle done_o=1, err_o=1, id=1.
REQ-034 Datapath never asserts done, TIMEOUT=64 -> done_o+err_o at RUN cycle 64, DRAIN, then IDLE.
REQ-035 Flags model returns 16'h0010 with done -> done_flags_o=16'h0010, overflow_o=1, both held until the next job completes.
REQ-036 rst_i pulsed mid-RUN -> no done_o; start low next cycle; next grant goes to requester 0.
